// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_stage
//  Description : Memory-access pipeline stage. Issues aligned data-memory
//                requests over a req/ready handshake, steers byte lanes,
//                sign/zero-extends loads, stalls upstream while a request is
//                outstanding and registers the result for writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_stage #(
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] pc_in,
    input  logic [DWIDTH-1:0] alu_result,
    input  logic [DWIDTH-1:0] rs2_data,
    input  logic [4:0]        rd_in,
    input  logic [2:0]        func3,
    input  logic              memR,
    input  logic              memW,
    input  logic              regW_in,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DWIDTH-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DWIDTH-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DWIDTH-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [DWIDTH-1:0] wb_pc,
    output logic [DWIDTH-1:0] wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_regW,
    output logic              misalign,
    output logic              bus_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    // Counter only needs to reach TIMEOUT-1; keep at least one bit.
    localparam int              c_CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_TMAX = c_CW'(TIMEOUT - 1);

    logic [0:0]        r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [DWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic [DWIDTH-1:0] r_pc;
    logic [2:0]        r_f3;
    logic [4:0]        r_rd;
    logic              r_regw;
    logic              r_we;

    logic              w_mem_op;
    logic              w_misalign;
    logic              w_timeout;
    logic [DWIDTH-1:0] w_shift;
    logic [DWIDTH-1:0] w_ld_data;
    logic              w_ld_ok;
    logic [3:0]        w_be;

    assign w_mem_op   = in_valid & (memR | memW);
    assign w_misalign = (((func3 == 3'b001) || (func3 == 3'b101)) && alu_result[0]) ||
                        ((func3 == 3'b010) && (alu_result[1:0] != 2'b00));
    assign w_timeout  = (r_state == S_REQ) && (r_cnt == c_TMAX) && !dmem_ready;

    // Request fields come only from the latched copy so they stay stable in REQ.
    assign dmem_req  = (r_state == S_REQ);
    assign dmem_we   = dmem_req & r_we;
    assign dmem_addr = {r_addr[DWIDTH-1:2], 2'b00};
    assign dmem_be   = dmem_req ? w_be : 4'b0000;

    // Upstream holds while a request is being accepted or is still waiting.
    assign stall = (r_state == S_IDLE) ? (w_mem_op & ~w_misalign)
                                       : (~dmem_ready & ~w_timeout);

    // Byte-lane enables and replicated store data from the access size.
    always_comb begin
        w_be       = 4'b0000;
        dmem_wdata = r_wdata;
        case (r_f3[1:0])
            2'b00: begin
                w_be       = 4'b0001 << r_addr[1:0];
                dmem_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be       = r_addr[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{r_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Shift the addressed lane down and extend it to a full word.
    always_comb begin
        w_shift   = dmem_rdata >> {r_addr[1:0], 3'b000};
        w_ld_data = '0;
        w_ld_ok   = 1'b1;
        case (r_f3)
            3'b000:  w_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b010:  w_ld_data = w_shift;
            3'b100:  w_ld_data = {24'h0, w_shift[7:0]};
            3'b101:  w_ld_data = {16'h0, w_shift[15:0]};
            default: w_ld_ok   = 1'b0;
        endcase
    end

    // Stage state machine, request latch and registered writeback outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_pc     <= '0;
            r_f3     <= 3'b000;
            r_rd     <= 5'd0;
            r_regw   <= 1'b0;
            r_we     <= 1'b0;
            wb_valid <= 1'b0;
            wb_pc    <= '0;
            wb_data  <= '0;
            wb_rd    <= 5'd0;
            wb_regW  <= 1'b0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_mem_op && w_misalign) begin
                        misalign <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_regW  <= 1'b0;
                        wb_data  <= '0;
                        wb_rd    <= rd_in;
                        wb_pc    <= pc_in;
                    end else if (w_mem_op) begin
                        r_state  <= S_REQ;
                        r_addr   <= alu_result;
                        r_wdata  <= rs2_data;
                        r_pc     <= pc_in;
                        r_f3     <= func3;
                        r_rd     <= rd_in;
                        r_regw   <= regW_in;
                        r_we     <= memW;
                        wb_valid <= 1'b0;
                    end else begin
                        wb_valid <= in_valid;
                        wb_data  <= alu_result;
                        wb_rd    <= rd_in;
                        wb_pc    <= pc_in;
                        wb_regW  <= regW_in & in_valid;
                    end
                end
                default: begin
                    wb_pc <= r_pc;
                    wb_rd <= r_rd;
                    if (dmem_ready) begin
                        r_state  <= S_IDLE;
                        r_cnt    <= '0;
                        wb_valid <= 1'b1;
                        wb_regW  <= r_we ? 1'b0 : (r_regw & w_ld_ok);
                        wb_data  <= r_we ? '0 : w_ld_data;
                    end else if (w_timeout) begin
                        r_state  <= S_IDLE;
                        r_cnt    <= '0;
                        bus_err  <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_regW  <= 1'b0;
                        wb_data  <= '0;
                    end else begin
                        r_cnt    <= r_cnt + c_CW'(1);
                        wb_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
